winograd_acc: RTL and testbench

- Sits directly downstream of the winograd dot-product array.
- Consumes the array's redundant output pair (two vectors whose sum is the dot-product partial) and resolves it with a final carry-propagate adder.
- Accumulates a variable-length group of partials into one saturating result and presents it on a valid/ready output port.
- Throughput: one partial per cycle, with backpressure toward the array's issue logic.

---
 rtl/winograd_pkg.sv | 44 ++++
 rtl/winograd_resolve.sv | 46 ++++
 rtl/winograd_acc.sv | 127 ++++++++++++
 tb/tb_winograd_acc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared types and saturating-add helper for the winograd accumulator slice.
package winograd_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAcc
  } state_e;

  // Working width for sat_add. Callers may pass any width up to SatW-2.
  localparam int unsigned SatW = 64;

  localparam int unsigned AccSizeDef = 32;
  localparam logic signed [AccSizeDef-1:0] AccMaxPos = {1'b0, {(AccSizeDef - 1){1'b1}}};
  localparam logic signed [AccSizeDef-1:0] AccMinNeg = {1'b1, {(AccSizeDef - 1){1'b0}}};

  typedef struct packed {
    logic signed [SatW-1:0] sum;
    logic                   ovf;
  } sat_t;

  // Adds two sign-extended operands and clamps the result to a signed 'width'-bit range.
  function automatic sat_t sat_add(input logic signed [SatW-1:0] base,
                                   input logic signed [SatW-1:0] inc,
                                   input int unsigned            width);
    sat_t                   r;
    logic signed [SatW-1:0] wide;
    logic signed [SatW-1:0] max_pos;
    logic signed [SatW-1:0] min_neg;
    wide    = base + inc;
    max_pos = $signed((SatW'(1) << (width - 1)) - SatW'(1));
    min_neg = ~max_pos;
    r.ovf   = 1'b1;
    if (wide > max_pos) begin
      r.sum = max_pos;
    end else if (wide < min_neg) begin
      r.sum = min_neg;
    end else begin
      r.sum = wide;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/winograd_resolve.sv
// Register stage that collapses a redundant vector pair into one sum, with a last flag
// and valid/stall control.
module winograd_resolve #(
  parameter int unsigned IN_SIZE = 26
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               accept_i,
  input  logic               stall_i,
  input  logic               last_i,
  input  logic [IN_SIZE-1:0] in_0_i,
  input  logic [IN_SIZE-1:0] in_1_i,
  output logic               valid_o,
  output logic               last_o,
  output logic [IN_SIZE:0]   sum_o
);

  logic             valid_q;
  logic             last_q;
  logic [IN_SIZE:0] sum_q;
  logic [IN_SIZE:0] sum_d;

  // One extra bit makes the carry-propagate add exact.
  always_comb begin
    sum_d = {in_0_i[IN_SIZE-1], in_0_i} + {in_1_i[IN_SIZE-1], in_1_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sum_q   <= '0;
    end else if (!stall_i) begin
      valid_q <= accept_i;
      if (accept_i) begin
        last_q <= last_i;
        sum_q  <= sum_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/winograd_acc.sv
// Resolves the dot-product array's redundant output and accumulates variable-length
// groups into a saturated result behind a valid/ready port.
module winograd_acc
  import winograd_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 26,
  parameter int unsigned ACC_SIZE = 32,
  parameter int unsigned CNT_SIZE = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_last_i,
  input  logic [IN_SIZE-1:0]  in_0_i,
  input  logic [IN_SIZE-1:0]  in_1_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] out_data_o,
  output logic                out_ovf_o,
  output logic [CNT_SIZE-1:0] out_beats_o
);

  logic             s1_valid;
  logic             s1_last;
  logic [IN_SIZE:0] s1_sum;
  logic             stall;
  logic             accept;
  logic             fire;
  logic             load;

  state_e                state_q, state_d;
  logic [ACC_SIZE-1:0]   acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_SIZE-1:0]   beats_q, beats_d;

  logic [ACC_SIZE-1:0]   base_acc;
  logic                  base_ovf;
  logic [CNT_SIZE-1:0]   base_beats;
  logic signed [SatW-1:0] base_w;
  logic signed [SatW-1:0] inc_w;
  sat_t                  sat_r;

  logic                  out_valid_q;
  logic [ACC_SIZE-1:0]   out_data_q;
  logic                  out_ovf_q;
  logic [CNT_SIZE-1:0]   out_beats_q;

  // Only a last beat needs the output register, so only it can stall.
  assign stall      = s1_valid && s1_last && out_valid_q && !out_ready_i;
  assign in_ready_o = !stall;
  assign accept     = in_valid_i && in_ready_o;
  assign fire       = s1_valid && !stall;

  winograd_resolve #(
    .IN_SIZE (IN_SIZE)
  ) u_resolve (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .accept_i (accept),
    .stall_i  (stall),
    .last_i   (in_last_i),
    .in_0_i   (in_0_i),
    .in_1_i   (in_1_i),
    .valid_o  (s1_valid),
    .last_o   (s1_last),
    .sum_o    (s1_sum)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    beats_d    = beats_q;
    load       = 1'b0;
    base_acc   = (state_q == StIdle) ? '0 : acc_q;
    base_ovf   = (state_q == StIdle) ? 1'b0 : ovf_q;
    base_beats = (state_q == StIdle) ? '0 : beats_q;
    base_w     = {{(SatW - ACC_SIZE){base_acc[ACC_SIZE-1]}}, base_acc};
    inc_w      = {{(SatW - IN_SIZE - 1){s1_sum[IN_SIZE]}}, s1_sum};
    sat_r      = sat_add(base_w, inc_w, ACC_SIZE);
    if (fire) begin
      acc_d   = sat_r.sum[ACC_SIZE-1:0];
      ovf_d   = base_ovf | sat_r.ovf;
      beats_d = (&base_beats) ? base_beats : base_beats + CNT_SIZE'(1);
      state_d = s1_last ? StIdle : StAcc;
      load    = s1_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      beats_q <= beats_d;
    end
  end

  // A fresh result takes priority over a same-cycle handshake, so nothing is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_d;
      out_ovf_q   <= ovf_d;
      out_beats_q <= beats_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_beats_o = out_beats_q;

endmodule

// File: tb/tb_winograd_acc.sv
// Self-checking bench for winograd_acc: directed scenarios plus randomized groups
// against a saturating arithmetic model.
module tb_winograd_acc;

  localparam int unsigned IN_SIZE  = 26;
  localparam int unsigned ACC_SIZE = 32;
  localparam int unsigned CNT_SIZE = 16;
  localparam longint MaxPos = 64'sd2147483647;
  localparam longint MinNeg = -64'sd2147483648;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [IN_SIZE-1:0]  in_0;
  logic [IN_SIZE-1:0]  in_1;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_SIZE-1:0] out_data;
  logic                out_ovf;
  logic [CNT_SIZE-1:0] out_beats;

  always #5 clk = ~clk;

  winograd_acc #(
    .IN_SIZE  (IN_SIZE),
    .ACC_SIZE (ACC_SIZE),
    .CNT_SIZE (CNT_SIZE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_last_i   (in_last),
    .in_0_i      (in_0),
    .in_1_i      (in_1),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf),
    .out_beats_o (out_beats)
  );

  typedef struct {
    longint data;
    bit     ovf;
    int     beats;
  } res_t;

  res_t   exp_q[$];
  longint mdl_acc;
  bit     mdl_ovf;
  int     mdl_beats;

  int  n_checks;
  int  n_pass;
  bit  rand_mode;
  bit  accepted;
  bit  hold_prev;
  logic [ACC_SIZE-1:0] prev_data;
  logic                prev_ovf;
  logic [CNT_SIZE-1:0] prev_beats;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: exact sum of the pair, added to the running value, clamped to 32-bit range.
  function automatic void mdl_beat(input longint a, input longint b, input bit last);
    longint w;
    w = mdl_acc + a + b;
    if (w > MaxPos) begin
      w = MaxPos;
      mdl_ovf = 1'b1;
    end else if (w < MinNeg) begin
      w = MinNeg;
      mdl_ovf = 1'b1;
    end
    mdl_acc = w;
    if (mdl_beats < 65535) mdl_beats++;
    if (last) begin
      exp_q.push_back('{data: mdl_acc, ovf: mdl_ovf, beats: mdl_beats});
      mdl_acc   = 0;
      mdl_ovf   = 1'b0;
      mdl_beats = 0;
    end
  endfunction

  function automatic void mdl_reset();
    mdl_acc   = 0;
    mdl_ovf   = 1'b0;
    mdl_beats = 0;
  endfunction

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic step();
    res_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (!rst) begin
      if (hold_prev) begin
        check_eq("hold_data", longint'(out_data), longint'(prev_data));
        check_eq("hold_ovf", longint'(out_ovf), longint'(prev_ovf));
        check_eq("hold_beats", longint'(out_beats), longint'(prev_beats));
      end
      if (out_valid && out_ready) begin
        check_eq("result_pending", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", longint'($signed(out_data)), e.data);
          check_eq("out_ovf", longint'(out_ovf), longint'(e.ovf));
          check_eq("out_beats", longint'(out_beats), longint'(e.beats));
        end
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ovf   = out_ovf;
      prev_beats = out_beats;
    end else begin
      hold_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send_beat(input longint a, input longint b, input bit last);
    int budget;
    budget = 0;
    in_0 = a[IN_SIZE-1:0];
    in_1 = b[IN_SIZE-1:0];
    do begin
      if (rand_mode && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_last  = last;
      end
      step();
      budget++;
    end while (!accepted && budget < 1000);
    check_eq("beat_accepted", longint'(accepted), 1);
    if (accepted) mdl_beat(a, b, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      step();
      budget++;
    end
    check_eq("drain_empty", longint'(exp_q.size()), 0);
  endtask

  function automatic longint rand_val(input bit big);
    logic signed [IN_SIZE-1:0] r;
    r = IN_SIZE'($urandom);
    if (big) return longint'(r);
    return longint'($urandom_range(0, 2000)) - 1000;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rand_mode = 1'b0;
    hold_prev = 1'b0;
    mdl_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_0      = '0;
    in_1      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_data", longint'(out_data), 0);
    check_eq("rst_out_ovf", longint'(out_ovf), 0);
    check_eq("rst_out_beats", longint'(out_beats), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", longint'(in_ready), 1);

    // Four-beat group and output latency
    out_ready = 1'b1;
    send_beat(100, -3, 1'b0);
    send_beat(7, 7, 1'b0);
    send_beat(-50, 0, 1'b0);
    send_beat(1, 1, 1'b1);
    check_eq("lat_valid_k1", longint'(out_valid), 0);
    step();
    check_eq("lat_valid_k2", longint'(out_valid), 1);
    check_eq("lat_data", longint'($signed(out_data)), 63);
    check_eq("lat_beats", longint'(out_beats), 4);
    step();
    check_eq("lat_valid_pulse", longint'(out_valid), 0);

    // Positive saturation, then a clean single-beat group
    for (int i = 0; i < 200; i++) send_beat(33554431, 33554431, i == 199);
    send_beat(-5, 2, 1'b1);
    drain();

    // Back-to-back single-beat groups against a blocked consumer
    out_ready = 1'b0;
    send_beat(1, 0, 1'b1);
    send_beat(2, 0, 1'b1);
    check_eq("stall_in_ready", longint'(in_ready), 0);
    check_eq("stall_out_valid", longint'(out_valid), 1);
    check_eq("stall_out_data", longint'($signed(out_data)), 1);
    in_0     = IN_SIZE'(3);
    in_1     = '0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_no_accept", longint'(accepted), 0);
    end
    out_ready = 1'b1;
    send_beat(3, 0, 1'b1);
    drain();

    // Reset in the middle of a group
    send_beat(5, 5, 1'b0);
    send_beat(6, 6, 1'b0);
    send_beat(7, 7, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mdl_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_mid_no_valid", longint'(out_valid), 0);
    end
    send_beat(10, 10, 1'b1);
    drain();

    // Randomized groups with random valid and ready
    rand_mode = 1'b1;
    for (int g = 0; g < 100; g++) begin
      int n;
      bit big;
      n   = $urandom_range(1, 40);
      big = 1'($urandom);
      for (int b = 0; b < n; b++) send_beat(rand_val(big), rand_val(big), b == n - 1);
    end
    drain();
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
